// File: rtl/alu_pkg.sv
// Shared ALU constants: operation encodings and condition-code bit positions.
// Imported by the datapath and the flag logic so both agree on one encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } alu_op_e;

    localparam int CC_W  = 3;
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle.
// The master drives operands; the slave (the ALU) returns registered results.
interface alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [1:0]       sel;
    logic [WIDTH-1:0] ALU_a;
    logic [WIDTH-1:0] ALU_b;
    logic             out_valid;
    logic [WIDTH-1:0] ALU_out;
    logic [2:0]       CCtemp;

    modport master (
        output in_valid, sel, ALU_a, ALU_b,
        input  out_valid, ALU_out, CCtemp
    );

    modport slave (
        input  in_valid, sel, ALU_a, ALU_b,
        output out_valid, ALU_out, CCtemp
    );
endinterface

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sub is a + ~b + 1 through the same adder.
// Overflow is the signed overflow of that one addition.
module alu_addsub #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] cin;

    // Invert b and inject a carry-in of one for subtraction.
    always_comb begin
        b_eff = sub ? ~b : b;
        cin   = {{(WIDTH-1){1'b0}}, sub};
        sum   = a + b_eff + cin;
        ovf   = (a[WIDTH-1] == b_eff[WIDTH-1])
              && (sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/alu.sv
// Single-cycle registered ALU: add/sub/and/xor with ZF/SF/OF flags.
// One result per in_valid cycle; outputs hold while in_valid is low.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic  clock,
    input  logic  reset_n,
    alu_if.slave  bus
);
    alu_op_e          op;
    logic [WIDTH-1:0] sum;
    logic             ovf;
    logic [WIDTH-1:0] result;
    logic [CC_W-1:0]  cc;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a   (bus.ALU_a),
        .b   (bus.ALU_b),
        .sub (op == OP_SUB),
        .sum (sum),
        .ovf (ovf)
    );

    // Select the result and derive the condition codes from it.
    always_comb begin
        op     = alu_op_e'(bus.sel);
        result = '0;
        cc     = '0;
        unique case (op)
            OP_ADD,
            OP_SUB: result = sum;
            OP_AND: result = bus.ALU_a & bus.ALU_b;
            OP_XOR: result = bus.ALU_a ^ bus.ALU_b;
            default: result = '0;
        endcase
        cc[CC_ZF] = (result == '0);
        cc[CC_SF] = result[WIDTH-1];
        cc[CC_OF] = (op == OP_ADD || op == OP_SUB) ? ovf : 1'b0;
    end

    // Capture result and flags on valid input; reset clears everything.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.ALU_out   <= '0;
            bus.CCtemp    <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.ALU_out <= result;
                bus.CCtemp  <= cc;
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// Directed testbench for the registered ALU.
// Each task drives vectors and compares {out_valid, CCtemp, ALU_out}.
module tb_alu;
    localparam int W = 64;

    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [W+3:0] obs();
        return {bus.out_valid, bus.CCtemp, bus.ALU_out};
    endfunction

    // Drive one valid op at the negedge; return #1 after the next posedge.
    task automatic apply(input logic [1:0] s,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.sel      = s;
        bus.ALU_a    = a;
        bus.ALU_b    = b;
        @(posedge clock);
        #1;
    endtask

    // One idle cycle with in_valid low.
    task automatic idle();
        @(negedge clock);
        bus.in_valid = 1'b0;
        bus.sel      = 2'd0;
        bus.ALU_a    = 64'h1234;
        bus.ALU_b    = 64'h4321;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [W+3:0] exp;
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.sel      = 2'd0;
        bus.ALU_a    = 64'd7;
        bus.ALU_b    = 64'd9;
        repeat (3) @(posedge clock);
        #1;
        exp = '0;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", obs(), exp);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_release_idle: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_add();
        logic [W+3:0] exp;
        apply(2'd0, 64'd5, 64'd3);
        exp = {1'b1, 3'b000, 64'd8};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL add_5_3: got %h want %h", obs(), exp);
        end
        idle();
        exp = {1'b0, 3'b000, 64'd8};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL add_hold: got %h want %h", obs(), exp);
        end
        apply(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        exp = {1'b1, 3'b100, 64'd0};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL add_carry_wrap: got %h want %h", obs(), exp);
        end
        apply(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        exp = {1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL add_neg_neg: got %h want %h", obs(), exp);
        end
        idle();
    endtask

    task automatic test_sub();
        logic [W+3:0] exp;
        apply(2'd1, 64'd16, 64'd8);
        exp = {1'b1, 3'b000, 64'd8};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sub_16_8: got %h want %h", obs(), exp);
        end
        apply(2'd1, 64'd8, 64'd8);
        exp = {1'b1, 3'b100, 64'd0};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sub_8_8: got %h want %h", obs(), exp);
        end
        apply(2'd1, 64'd0, 64'd1);
        exp = {1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sub_0_1: got %h want %h", obs(), exp);
        end
        idle();
    endtask

    task automatic test_overflow();
        logic [W+3:0] exp;
        apply(2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        exp = {1'b1, 3'b011, 64'h8000_0000_0000_0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL add_ovf: got %h want %h", obs(), exp);
        end
        apply(2'd1, 64'h8000_0000_0000_0000, 64'd1);
        exp = {1'b1, 3'b001, 64'h7FFF_FFFF_FFFF_FFFF};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sub_ovf: got %h want %h", obs(), exp);
        end
        apply(2'd1, 64'd5, 64'h8000_0000_0000_0000);
        exp = {1'b1, 3'b011, 64'h8000_0000_0000_0005};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL sub_pos_minus_min: got %h want %h", obs(), exp);
        end
        idle();
    endtask

    task automatic test_logic();
        logic [W+3:0] exp;
        apply(2'd2, 64'hF0, 64'h0F);
        exp = {1'b1, 3'b100, 64'd0};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL and_f0_0f: got %h want %h", obs(), exp);
        end
        apply(2'd3, 64'h8000_0000_0000_0000, 64'd0);
        exp = {1'b1, 3'b010, 64'h8000_0000_0000_0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL xor_msb: got %h want %h", obs(), exp);
        end
        apply(2'd2, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0);
        exp = {1'b1, 3'b010, 64'hF0F0_0000_F0F0_0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL and_mask: got %h want %h", obs(), exp);
        end
        apply(2'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        exp = {1'b1, 3'b010, 64'h8000_0000_0000_0000};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL xor_no_of: got %h want %h", obs(), exp);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [W+3:0] exp;
        apply(2'd0, 64'd1, 64'd2);
        exp = {1'b1, 3'b000, 64'd3};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL b2b_0: got %h want %h", obs(), exp);
        end
        apply(2'd1, 64'd3, 64'd5);
        exp = {1'b1, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL b2b_1: got %h want %h", obs(), exp);
        end
        apply(2'd3, 64'hFF, 64'h0F);
        exp = {1'b1, 3'b000, 64'hF0};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL b2b_2: got %h want %h", obs(), exp);
        end
        idle();
        exp = {1'b0, 3'b000, 64'hF0};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL b2b_idle1: got %h want %h", obs(), exp);
        end
        idle();
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL b2b_idle2: got %h want %h", obs(), exp);
        end
    endtask

    task automatic test_midstream_reset();
        logic [W+3:0] exp;
        apply(2'd0, 64'd100, 64'd23);
        exp = {1'b1, 3'b000, 64'd123};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL pre_reset: got %h want %h", obs(), exp);
        end
        bus.sel   = 2'd1;
        bus.ALU_a = 64'd50;
        bus.ALU_b = 64'd60;
        #1;
        reset_n = 1'b0;
        #1;
        exp = '0;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", obs(), exp);
        end
        @(posedge clock);
        #1;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL reset_edge: got %h want %h", obs(), exp);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        @(posedge clock);
        #1;
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL no_inflight: got %h want %h", obs(), exp);
        end
        apply(2'd0, 64'd2, 64'd2);
        exp = {1'b1, 3'b000, 64'd4};
        vectors++;
        if (obs() !== exp) begin
            miscompares++;
            $display("FAIL post_reset_op: got %h want %h", obs(), exp);
        end
        idle();
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel      = 2'd0;
        bus.ALU_a    = '0;
        bus.ALU_b    = '0;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
